// File: rtl/m_unit_pkg.sv
// rtl/m_unit_pkg.sv - shared constants and types for the RV32M multiply/divide unit
package m_unit_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] M_OPCODE = 7'b0110011;
    localparam logic [6:0] M_FUNC7  = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_e;

    // {op1 is signed, op2 is signed} for a given func3
    function automatic logic [1:0] op_signedness(input logic [2:0] f3);
        case (f3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: op_signedness = 2'b11;
            F3_MULHSU:                       op_signedness = 2'b10;
            default:                         op_signedness = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/m_unit_iter.sv
// rtl/m_unit_iter.sv - one shift-add (multiply) or restoring-divide step
module m_unit_iter #(
    parameter int XLEN = 32
) (
    input  logic            div_mode_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] operand_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   r_sh;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, operand_i} : '0);
        // 33-bit partial remainder: previous remainder with the next dividend bit shifted in
        r_sh = {hi_i, lo_i[XLEN-1]};
        ge   = (r_sh >= {1'b0, operand_i});
        diff = r_sh[XLEN-1:0] - operand_i;
        if (div_mode_i) begin
            hi_o = ge ? diff : r_sh[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], ge};
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/m_unit.sv
// rtl/m_unit.sv - iterative RV32M multiply/divide unit with fixed 34-cycle latency
module m_unit
    import m_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [4:0]      rd,
    output logic            m_unit_busy,
    output logic            m_unit_ready,
    output logic            m_unit_wr,
    output logic [4:0]      m_unit_dest,
    output logic [XLEN-1:0] m_unit_result
);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          func3_q;
    logic [4:0]          rd_q;
    logic [XLEN-1:0]     operand_q, hi_q, lo_q, op1_raw_q;
    logic                neg_main_q, neg_rem_q, div0_q;
    logic                busy_q, ready_q, wr_q;
    logic [4:0]          dest_q;
    logic [XLEN-1:0]     result_q;

    logic [1:0]          sgn;
    logic                s1, s2, is_div;
    logic [XLEN-1:0]     mag1, mag2;
    logic [XLEN-1:0]     hi_d, lo_d, result_d;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix, rem_fix;

    always_comb begin
        sgn    = op_signedness(func3);
        s1     = sgn[1] & op1[XLEN-1];
        s2     = sgn[0] & op2[XLEN-1];
        is_div = func3[2];
        mag1   = s1 ? -op1 : op1;
        mag2   = s2 ? -op2 : op2;
    end

    m_unit_iter #(.XLEN(XLEN)) u_iter (
        .div_mode_i (func3_q[2]),
        .hi_i       (hi_q),
        .lo_i       (lo_q),
        .operand_i  (operand_q),
        .hi_o       (hi_d),
        .lo_o       (lo_d)
    );

    // Sign correction and the divide-by-zero override happen once, on the final value
    always_comb begin
        prod_fix = neg_main_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quot_fix = neg_main_q ? -lo_q : lo_q;
        rem_fix  = neg_rem_q ? -hi_q : hi_q;
        case (func3_q)
            F3_MUL:                       result_d = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result_d = div0_q ? '1 : quot_fix;
            default:                      result_d = div0_q ? op1_raw_q : rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            func3_q    <= '0;
            rd_q       <= '0;
            operand_q  <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            op1_raw_q  <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            wr_q       <= 1'b0;
            dest_q     <= '0;
            result_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b0;
                    wr_q    <= 1'b0;
                    if (start && !flush) begin
                        state_q    <= ST_CALC;
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        func3_q    <= func3;
                        rd_q       <= rd;
                        operand_q  <= is_div ? mag2 : mag1;
                        lo_q       <= is_div ? mag1 : mag2;
                        hi_q       <= '0;
                        op1_raw_q  <= op1;
                        neg_main_q <= s1 ^ s2;
                        neg_rem_q  <= s1;
                        div0_q     <= (op2 == '0);
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hi_q <= hi_d;
                        lo_q <= lo_d;
                        if (cnt_q == CNT_W'(XLEN - 1)) begin
                            state_q <= ST_DONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b0;
                        wr_q    <= 1'b0;
                    end else if (!ready_q) begin
                        result_q <= result_d;
                        dest_q   <= rd_q;
                        ready_q  <= 1'b1;
                        wr_q     <= (rd_q != 5'd0);
                        busy_q   <= 1'b0;
                    end else begin
                        ready_q <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_unit_busy   = busy_q;
    assign m_unit_ready  = ready_q;
    assign m_unit_wr     = wr_q;
    assign m_unit_dest   = dest_q;
    assign m_unit_result = result_q;

endmodule

// File: tb/tb_m_unit.sv
// tb/tb_m_unit.sv - randomized self-checking bench for m_unit against an arithmetic reference model
module tb_m_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  func3;
    logic [31:0] op1, op2;
    logic [4:0]  rd;
    logic        busy, ready, wr;
    logic [4:0]  dest;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_res = 32'h0;

    m_unit dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .flush         (flush),
        .func3         (func3),
        .op1           (op1),
        .op2           (op2),
        .rd            (rd),
        .m_unit_busy   (busy),
        .m_unit_ready  (ready),
        .m_unit_wr     (wr),
        .m_unit_dest   (dest),
        .m_unit_result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        model = 32'h0;
        case (f3)
            3'd0: begin sp = sa * sb; model = sp[31:0]; end
            3'd1: begin sp = sa * sb; model = sp[63:32]; end
            3'd2: begin sp = sa * longint'(ub); model = sp[63:32]; end
            3'd3: begin up = ua * ub; model = up[63:32]; end
            3'd4: begin
                if (b == 0) model = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h8000_0000;
                else begin sp = sa / sb; model = sp[31:0]; end
            end
            3'd5: begin
                if (b == 0) model = 32'hFFFF_FFFF;
                else begin up = ua / ub; model = up[31:0]; end
            end
            3'd6: begin
                if (b == 0) model = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = 32'h0;
                else begin sp = sa % sb; model = sp[31:0]; end
            end
            default: begin
                if (b == 0) model = a;
                else begin up = ua % ub; model = up[31:0]; end
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       pick_operand = 32'h0;
            1:       pick_operand = 32'h1;
            2:       pick_operand = 32'hFFFF_FFFF;
            3:       pick_operand = 32'h8000_0000;
            4:       pick_operand = 32'h7FFF_FFFF;
            5:       pick_operand = 32'($urandom_range(0, 255));
            default: pick_operand = $urandom;
        endcase
    endfunction

    // Issues one op and checks latency, pulse width and the delivered result
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] exp, input bit hold);
        int lat;
        bit busy_drop;
        @(negedge clk);
        start = 1'b1; func3 = f3; op1 = a; op2 = b; rd = r;
        lat = 0;
        busy_drop = 1'b0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (!hold) start = 1'b0;
            if (ready) break;
            if (!busy) busy_drop = 1'b1;
        end
        if (!ready) begin
            check("timeout", 32'(ready), 32'h1);
            start = 1'b0;
            return;
        end
        check("latency", 32'(lat), 32'd34);
        check("busy_during_op", 32'(busy_drop), 32'h0);
        check("busy_at_ready", 32'(busy), 32'h0);
        check("result", result, exp);
        check("dest", 32'(dest), 32'(r));
        check("wr", 32'(wr), 32'(r != 5'd0));
        last_res = exp;
        if (hold) flush = 1'b1;
        @(negedge clk);
        check("ready_pulse_width", 32'(ready), 32'h0);
        if (hold) begin
            @(negedge clk);
            check("start_flush_rejected", 32'(busy), 32'h0);
            start = 1'b0;
            flush = 1'b0;
        end
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ready || busy) pulses++;
        end
        check(tag, 32'(pulses), 32'h0);
    endtask

    logic [2:0]  d_f3  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd20, 32'd20,
                                32'hFFFF_FFFF, 32'd100, 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFD,
                                32'd3, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd2,
                                32'h5555_5555, 32'd2, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0};

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  r;
        int n;
        rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0; op1 = '0; op2 = '0; rd = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_wr", 32'(wr), 32'h0);
        check("reset_dest", 32'(dest), 32'h0);
        check("reset_result", result, 32'h0);

        for (int i = 0; i < 12; i++) begin
            run_op(d_f3[i], d_a[i], d_b[i], 5'(i + 1), d_exp[i], 1'b0);
        end

        run_op(3'd0, 32'd3, 32'd4, 5'd0, 32'd12, 1'b0);

        // flush mid-divide: no pulse, result untouched, then a clean restart
        @(negedge clk);
        start = 1'b1; func3 = 3'd4; op1 = 32'd1000; op2 = 32'd7; rd = 5'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'h0);
        check("flush_ready", 32'(ready), 32'h0);
        check("flush_result_kept", result, last_res);
        run_op(3'd4, 32'd1000, 32'd7, 5'd9, 32'd142, 1'b0);

        run_op(3'd1, 32'h1234_5678, 32'hFEDC_BA98, 5'd17, model(3'd1, 32'h1234_5678, 32'hFEDC_BA98), 1'b1);
        expect_quiet("no_rearm_after_hold", 40);

        // synchronous reset while iterating
        @(negedge clk);
        start = 1'b1; func3 = 3'd0; op1 = 32'd5; op2 = 32'd6; rd = 5'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_ready", 32'(ready), 32'h0);
        check("rst_mid_wr", 32'(wr), 32'h0);
        check("rst_mid_dest", 32'(dest), 32'h0);
        check("rst_mid_result", result, 32'h0);
        expect_quiet("no_pulse_after_rst", 40);

        n = 0;
        while (n < 48) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            r  = 5'($urandom_range(0, 31));
            run_op(f3, a, b, r, model(f3, a, b), 1'b0);
            n++;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
